// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract as NSTG = WIDTH/SEG ripple segments, one per stage; latency NSTG cycles.
// Backpressure: the whole pipeline holds while the result is valid and not taken; in_ready = advance enable.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int NSTG = WIDTH / SEG;

  logic             en;
  logic [WIDTH-1:0] beff;
  logic             c0;

  logic [NSTG-1:0]  vld_q;
  logic [WIDTH-1:0] a_q  [NSTG];
  logic [WIDTH-1:0] b_q  [NSTG];
  logic [WIDTH-1:0] s_q  [NSTG];
  logic             c_q  [NSTG];
  logic             v_q;
  logic             z_q;

  logic [WIDTH-1:0] a_in [NSTG];
  logic [WIDTH-1:0] b_in [NSTG];
  logic [WIDTH-1:0] s_in [NSTG];
  logic             c_in [NSTG];
  logic [SEG:0]     seg  [NSTG];
  logic [WIDTH-1:0] s_n  [NSTG];
  logic             c_n  [NSTG];
  logic             v_n;
  logic             z_n;

  assign en       = !vld_q[NSTG-1] || out_ready;
  assign in_ready = en;

  // Subtraction becomes A + ~B + ~Cin, so every stage is a plain adder.
  assign beff = sub ? ~B : B;
  assign c0   = sub ? ~Cin : Cin;

  // Stage k works on what stage k-1 registered; stage 0 works on the live operands.
  always_comb begin
    a_in[0] = A;
    b_in[0] = beff;
    c_in[0] = c0;
    s_in[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      seg[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
             + {{SEG{1'b0}}, c_in[k]};
      s_n[k] = s_in[k];
      s_n[k][k*SEG +: SEG] = seg[k][SEG-1:0];
      c_n[k] = seg[k][SEG];
    end
  end

  // Like-signed operands giving an opposite-signed sum is exactly carry-in(MSB) ^ carry-out(MSB).
  assign v_n = (a_in[NSTG-1][WIDTH-1] ~^ b_in[NSTG-1][WIDTH-1])
             & (s_n[NSTG-1][WIDTH-1] ^ a_in[NSTG-1][WIDTH-1]);
  assign z_n = ~|s_n[NSTG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < NSTG; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
      end
      v_q <= v_n;
      z_q <= z_n;
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign S         = s_q[NSTG-1];
  assign Cout      = c_q[NSTG-1];
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table, backpressure, mid-flight reset and random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_addsub;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSTG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             Z;

  pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             v;
    logic             z;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sb;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             v;
    logic             z;
  } vec_t;

  vec_t tbl [10];
  res_t expq [$];
  int   nvec = 0;
  int   nerr = 0;
  int   popped = 0;
  bit   hold_pend = 0;
  res_t held;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sb);
    res_t   r;
    longint ua, ub, sa, sbv, ru, rs, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    if (sb) begin
      ru     = ua - ub - longint'(ci);
      rs     = sa - sbv - longint'(ci);
      r.cout = (ua >= ub + longint'(ci));
    end else begin
      ru     = ua + ub + longint'(ci);
      rs     = sa + sbv + longint'(ci);
      r.cout = ru[WIDTH];
    end
    r.s = ru[WIDTH-1:0];
    r.v = (rs > smax) || (rs < smin);
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: settle, account for the handshakes that the coming edge performs, then advance.
  task automatic cycle(output bit acc);
    res_t got;
    res_t e;
    acc = 0;
    #1;
    got = '{s: S, cout: Cout, v: V, z: Z};
    if (rst) begin
      expq.delete();
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_data", 32'(got), 32'(held));
      end
      hold_pend = out_valid && !out_ready;
      held      = got;
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) begin
        expq.push_back(model(A, B, Cin, sub));
        acc = 1;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious: got result 0x%0h, expected none", S);
        end else begin
          e = expq.pop_front();
          chk("result", 32'(got), 32'(e));
          popped++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    bit acc;
    int lat;
    A = t.a; B = t.b; Cin = t.cin; sub = t.sb;
    in_valid  = 1;
    out_ready = 1;
    cycle(acc);
    chk({tag, "_acc"}, 32'(acc), 32'(1));
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle(acc);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(NSTG - 1));
    chk({tag, "_S"}, 32'(S), 32'(t.s));
    chk({tag, "_Cout"}, 32'(Cout), 32'(t.cout));
    chk({tag, "_V"}, 32'(V), 32'(t.v));
    chk({tag, "_Z"}, 32'(Z), 32'(t.z));
    cycle(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    bit               acc;
    int               c;
    int               idx;
    logic [WIDTH-1:0] ra [8];
    logic [WIDTH-1:0] rb [8];
    logic             rc [8];
    logic             rs [8];

    rst = 1; in_valid = 0; out_ready = 1; A = '0; B = '0; Cin = 0; sub = 0;

    //             a        b        cin   sb    s        cout  v     z
    tbl[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    // Reset and idle
    cycle(acc);
    cycle(acc);
    rst = 0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_S", 32'(S), 32'(0));
    chk("rst_Cout", 32'(Cout), 32'(0));
    chk("rst_V", 32'(V), 32'(0));
    chk("rst_Z", 32'(Z), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 10; i++) begin
      chk("idle_out_valid", 32'(out_valid), 32'(0));
      cycle(acc);
    end

    // Directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Back-to-back stream with a 3-cycle downstream stall
    for (int i = 0; i < 8; i++) begin
      ra[i] = WIDTH'($urandom);
      rb[i] = WIDTH'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    popped = 0;
    idx = 0;
    c = 0;
    in_valid = 1;
    while (idx < 8 && c < 60) begin
      A = ra[idx]; B = rb[idx]; Cin = rc[idx]; sub = rs[idx];
      out_ready = !(c >= 5 && c <= 7);
      cycle(acc);
      if (acc) idx++;
      c++;
    end
    chk("bp_all_accepted", 32'(idx), 32'(8));
    in_valid  = 0;
    out_ready = 1;
    c = 0;
    while (expq.size() != 0 && c < 40) begin
      cycle(acc);
      c++;
    end
    chk("bp_drained", 32'(expq.size()), 32'(0));
    chk("bp_count", 32'(popped), 32'(8));

    // Reset with three operations in flight
    out_ready = 1;
    in_valid  = 1;
    for (int i = 0; i < 3; i++) begin
      A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      cycle(acc);
      chk("mid_acc", 32'(acc), 32'(1));
    end
    in_valid = 0;
    rst = 1;
    cycle(acc);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      chk("mid_no_output", 32'(out_valid), 32'(0));
      cycle(acc);
    end
    run_vec(tbl[0], "after_rst");

    // Random traffic with random backpressure
    popped = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      cycle(acc);
    end
    in_valid  = 0;
    out_ready = 1;
    c = 0;
    while (expq.size() != 0 && c < 40) begin
      cycle(acc);
      c++;
    end
    chk("rand_drained", 32'(expq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
